// File: rtl/palmpilot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : palmpilot_pkg
// Description : Shared widths, limits and state encoding for the score timer
//               and the leaderboard it feeds. Also holds the helper that maps
//               a raw tick count onto a reportable (non-zero) score.
// Revision    : 1.0 - initial release
// ============================================================================
package palmpilot_pkg;

  // Score width and saturation ceiling shared with the leaderboard.
  localparam int SCORE_W   = 10;
  localparam int SCORE_MAX = 1023;

  typedef logic [SCORE_W-1:0] score_t;

  // Round state encoding; kept as plain constants so legacy blocks that
  // compare raw state bits stay compatible.
  localparam int         STATE_W = 2;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RUN     = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  // A score of 0 means "empty slot" downstream, so a completed round that
  // never saw a tick still reports 1.
  function automatic score_t score_floor(input score_t v);
    return (v == '0) ? score_t'(1) : v;
  endfunction

endpackage : palmpilot_pkg
`default_nettype wire

// File: rtl/score_timer_if.sv
`default_nettype none
// ============================================================================
// Module      : score_timer_if
// Description : Control/result bundle between a game controller (master) and
//               the score timer (slave).
//   start     : master -> slave, level, begins a round from IDLE
//   finish    : master -> slave, level, ends the running round successfully
//   abort     : master -> slave, level, discards the running round
//   penalty   : master -> slave, one-cycle pulse (only with SCORE_PENALTY_EN)
//   new_score : slave -> master, final score, non-zero for one cycle per round
//   elapsed   : slave -> master, live tick count of current/last round
//   busy      : slave -> master, high while a round runs
// Build macro : SCORE_PENALTY_EN adds the penalty signal.
// Revision    : 1.0 - initial release
// ============================================================================
interface score_timer_if;
  import palmpilot_pkg::*;

  logic   start;
  logic   finish;
  logic   abort;
`ifdef SCORE_PENALTY_EN
  logic   penalty;
`endif
  score_t new_score;
  score_t elapsed;
  logic   busy;

  modport master (
`ifdef SCORE_PENALTY_EN
    output penalty,
`endif
    output start,
    output finish,
    output abort,
    input  new_score,
    input  elapsed,
    input  busy
  );

  modport slave (
`ifdef SCORE_PENALTY_EN
    input  penalty,
`endif
    input  start,
    input  finish,
    input  abort,
    output new_score,
    output elapsed,
    output busy
  );

endinterface : score_timer_if
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : tick_prescaler
// Description : Divides clk down to a one-cycle tick every DIV enabled cycles.
//               The first tick after a clear lands DIV enabled cycles later.
//   clk     : in  system clock
//   reset_n : in  asynchronous active-low reset
//   clear   : in  restart the division count (has priority over enable)
//   enable  : in  advance the count this cycle
//   tick    : out high during the last cycle of each DIV-cycle period
// Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int               CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // tick is combinational so the consumer counts it on the same edge that
  // wraps the counter; this makes the tick land exactly DIV edges after clear.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : tick_prescaler
`default_nettype wire

// File: rtl/score_timer.sv
`default_nettype none
// ============================================================================
// Module      : score_timer
// Description : Times one game round in ticks of 1/TICK_HZ seconds and hands
//               the result to the leaderboard as a single-cycle new_score.
//   clk     : in  system clock (CLK_HZ)
//   reset_n : in  asynchronous active-low reset
//   bus     : score_timer_if.slave - start/finish/abort(/penalty) in,
//             new_score/elapsed/busy out
// Build macro : SCORE_PENALTY_EN - adds the penalty input; each pulse in RUN
//               adds PENALTY_TICKS to the elapsed count.
// Revision    : 1.0 - initial release
// ============================================================================
module score_timer
  import palmpilot_pkg::*;
#(
  parameter int CLK_HZ        = 100000000,
  parameter int TICK_HZ       = 10,
  parameter int PENALTY_TICKS = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  score_timer_if.slave        bus
);

  // Nonsensical parameter sets fall back to ticking every cycle instead of
  // dividing by zero at elaboration.
  localparam bit PARAMS_OK = (TICK_HZ > 0) && (CLK_HZ >= TICK_HZ) &&
                             (PENALTY_TICKS >= 0);
  localparam int DIV       = PARAMS_OK ?
                             (CLK_HZ / ((TICK_HZ > 0) ? TICK_HZ : 1)) : 1;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  score_t             elapsed_q;
  score_t             elapsed_d;
  score_t             elapsed_inc;
  logic [31:0]        sum;
  logic               tick;
  logic               presc_clear;
  logic               presc_en;

  // The prescaler restarts on the same edge that accepts start, so every
  // round gets a full DIV cycles before its first point.
  assign presc_clear = (state_q == IDLE) && bus.start;
  assign presc_en    = (state_q == RUN);

  tick_prescaler #(
    .DIV     (DIV)
  ) u_tick_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (presc_clear),
    .enable  (presc_en),
    .tick    (tick)
  );

  // Elapsed update for a RUN cycle: tick and penalty may coincide and both
  // count. Summed wide so the saturation compare cannot wrap.
  always_comb begin
    sum = 32'(elapsed_q) + 32'(tick);
`ifdef SCORE_PENALTY_EN
    if (bus.penalty) begin
      sum = sum + 32'(PENALTY_TICKS);
    end
`endif
    elapsed_inc = (sum > 32'(SCORE_MAX)) ? score_t'(SCORE_MAX) : score_t'(sum);
  end

  // Round control. The update is applied on the finish edge as well, so a
  // tick landing on that edge is part of the captured score.
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          elapsed_d = '0;
        end
      end
      RUN: begin
        elapsed_d = elapsed_inc;
        if (bus.abort) begin
          state_d = IDLE;
        end else if (bus.finish) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      elapsed_q <= '0;
    end else begin
      state_q   <= state_d;
      elapsed_q <= elapsed_d;
    end
  end

  // Decoded from state so reset clears the pulse immediately.
  assign bus.new_score = (state_q == DONE) ? score_floor(elapsed_q) : '0;
  assign bus.elapsed   = elapsed_q;
  assign bus.busy      = (state_q == RUN);

endmodule : score_timer
`default_nettype wire
